// File: rtl/wordcnt_pkg.sv
// wordcnt_pkg: shared types, defaults and terminal-condition helper for the word counter
package wordcnt_pkg;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_t;
  localparam int DEF_WIDTH = 8;
  function automatic logic is_term(input logic [31:0] q, input logic [31:0] lim, input logic up);
    return up ? (q >= lim) : (q == 32'd0);
  endfunction
endpackage

// File: rtl/wordcnt_if.sv
// wordcnt_if: control/data bundle between a counter stage and its driver
interface wordcnt_if import wordcnt_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] data, lim, q;
  logic clr, pl, en, inc, dec, ci_n, ovf_clr, co_n, zero, tc, ovf;
  modport master(output data, lim, clr, pl, en, inc, dec, ci_n, ovf_clr, input q, co_n, zero, tc, ovf);
  modport slave(input data, lim, clr, pl, en, inc, dec, ci_n, ovf_clr, output q, co_n, zero, tc, ovf);
endinterface

// File: rtl/wordcnt_term.sv
// wordcnt_term: combinational at-limit and at-zero detection for the counter value
module wordcnt_term import wordcnt_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] lim,
  output logic             at_max,
  output logic             at_zero
);
  assign at_max = is_term(32'(q), 32'(lim), 1'b1);
  assign at_zero = is_term(32'(q), 32'(lim), 1'b0);
endmodule

// File: rtl/wordcnt_gen.sv
// wordcnt_gen: cascadable up/down word counter with limit, wrap/saturate mode, tc pulse and sticky ovf
module wordcnt_gen import wordcnt_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MODE  = 0
) (
  input logic     clk,
  input logic     resn,
  wordcnt_if.slave bus
);
  localparam logic sat = (MODE == int'(CNT_SAT));
  logic [WIDTH-1:0] q_d, q_q, cnt_v, ld_v;
  logic tc_d, tc_q, ovf_d, ovf_q, at_max, at_zero, step, up, term, sat_set;
  wordcnt_term #(.WIDTH(WIDTH)) u_term (.q(q_q), .lim(bus.lim), .at_max(at_max), .at_zero(at_zero));
  always_comb begin
    step = bus.en & ~bus.ci_n & (bus.inc ^ bus.dec);
    up = bus.inc & ~bus.dec;
    term = step & (up ? at_max : at_zero);
    ld_v = (bus.data > bus.lim) ? bus.lim : bus.data;
    cnt_v = up ? (at_max ? (sat ? bus.lim : '0) : q_q + WIDTH'(1))
               : (at_zero ? (sat ? '0 : bus.lim) : q_q - WIDTH'(1));
    sat_set = sat & term & ~bus.clr & ~bus.pl;
    q_d = bus.clr ? '0 : bus.pl ? ld_v : step ? cnt_v : q_q;
    tc_d = term & ~bus.clr & ~bus.pl;
    ovf_d = bus.clr ? 1'b0 : sat_set ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      q_q <= '0;
      tc_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q <= q_d;
      tc_q <= tc_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.q = q_q;
  assign bus.co_n = ~term;
  assign bus.zero = at_zero;
  assign bus.tc = tc_q;
  assign bus.ovf = ovf_q;
endmodule

// File: doc/wordcnt_gen.md
Name: wordcnt_gen

Overview:
Parametrised up/down word counter: next generation of the team's 8-bit word counter. Adds configurable width, wrap or saturate mode, a programmable upper limit (modulus), a registered terminal-count pulse and a sticky overflow flag. Keeps the active-low carry chain so stages cascade into wider counters. Used for word/byte counting in the datapath control.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MODE, 0, 0 = wrap at limits, 1 = saturate at limits

Ports:
clk  input  1  clock, all state updates on rising edge
resn  input  1  asynchronous active-low reset
data  input  WIDTH  parallel-load value
lim  input  WIDTH  upper count limit (count range 0..lim); tie to all-ones for full range
clr  input  1  synchronous clear
pl  input  1  parallel load
en  input  1  count enable
inc  input  1  count-up request
dec  input  1  count-down request
ci_n  input  1  active-low carry/borrow in; tie 0 on the lowest stage
q  output  WIDTH  counter value (registered)
co_n  output  1  active-low carry/borrow out, combinational
zero  output  1  q == 0, combinational from q
tc  output  1  registered one-cycle terminal-count pulse
ovf  output  1  sticky overflow/underflow flag (MODE 1 only)
ovf_clr  input  1  clears ovf

Behaviour:
- resn low (asynchronous): q=0, tc=0, ovf=0 immediately, held while low. Release is synchronous to clk by the system.
- Per-edge priority: clr > pl > count > hold.
- clr: q=0, ovf=0, tc=0.
- pl: q = data if data <= lim, otherwise q = lim. tc=0. ovf unchanged.
- Count step is active when en=1 and ci_n=0 and inc != dec. inc=dec=1 holds q with no tc and no co_n. en=0 or ci_n=1 holds q.
- Up step, q < lim: q = q+1.
- Up step, q >= lim, MODE 0: q = 0 and tc=1 on the next cycle.
- Up step, q >= lim, MODE 1: q = lim, ovf set, tc=1 on the next cycle.
- Down step, q > 0: q = q-1. This also applies when q > lim after a limit change.
- Down step, q == 0, MODE 0: q = lim and tc=1 on the next cycle.
- Down step, q == 0, MODE 1: q holds at 0, ovf set, tc=1 on the next cycle.
- tc is high for exactly one cycle after each terminal event and is low otherwise. Back-to-back terminal events give back-to-back tc cycles.
- co_n = NOT( en AND NOT ci_n AND ((inc AND NOT dec AND q>=lim) OR (dec AND NOT inc AND q==0)) ).
- co_n is forced high when ci_n=1. It is evaluated regardless of clr/pl; the upstream stage gates its own en.
- Cascading: connect co_n of stage k to ci_n of stage k+1, with a shared en/inc/dec. Stage k+1 steps only on the cycle stage k wraps.
- ovf: set by a saturate event. ovf_clr clears it. A set and ovf_clr in the same cycle leave ovf=1. In MODE 0, ovf stays 0.
- A lim change takes effect on the next edge. There is no retroactive clamp of q.
- Arithmetic is unsigned WIDTH-bit with no intermediate overflow: compares use >=, never +1 overflow.
- zero is combinational from q.

Decomposition:
- Package wordcnt_pkg:
  - enum cnt_mode_t {CNT_WRAP=0, CNT_SAT=1}
  - localparams for default WIDTH
  - function is_term(q, lim, up) returning the terminal condition
- Sub-module wordcnt_term: combinational terminal detect (at_max, at_zero) shared by the next-state logic and co_n.
- Two-stage cascade wrapper: the bench only, not RTL.

Test Plan:
- Reset/load: resn pulse mid-count (q=0x37) -> q=0, tc=0, ovf=0 immediately; then pl with data=0x20, lim=0xFF -> q=0x20 next edge.
- Wrap up, MODE 0: lim=0x05, q=0x04, en=inc=1, 3 cycles -> q=0x05, 0x00, 0x01; co_n low only while q=0x05; tc high exactly one cycle after q returns to 0.
- Wrap down: lim=0x05, q=0x00, dec=1 -> q=0x05, tc pulse. Then inc=dec=1 for 2 cycles -> q holds at 0x05, no tc.
- Saturate, MODE 1: lim=0xFF, q=0xFE, inc 3 cycles -> q=0xFF, 0xFF, 0xFF; ovf set; tc high on 2 cycles. ovf_clr together with another saturate -> ovf stays 1. ovf_clr alone -> 0.
- Cascade: two WIDTH=4 stages, MODE 0, lim=0xF, inc from 0x0F -> combined value 0x10 in one edge. dec from 0x10 -> 0x0F. ci_n=1 on the low stage -> no change.
- Limit/priority edges:
  - pl data=0x40 with lim=0x30 -> q=0x30.
  - lim lowered to 0x10 with q=0x30, inc -> q=0x00.
  - clr+pl+inc in the same cycle -> q=0.
